// File: rtl/dsp_dual_bank_mem.sv
//------------------------------------------------------------------------------
// dsp_dual_bank_mem
// Two-bank data memory for the DSP memory stage. Each bank has a registered
// read port, and stores are steered to a bank by the address MSB. A clear
// sequencer zero-fills both banks after reset.
// Optional feature macro: DSPMEM_FWD_EN (write-first forwarding on collisions).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef MEM_ADDR_LEN
`define MEM_ADDR_LEN 8
`endif
`ifndef REG_WORD_LEN
`define REG_WORD_LEN 16
`endif

module dsp_dual_bank_mem #(
    parameter int ADDR_W = `MEM_ADDR_LEN,
    parameter int DATA_W = `REG_WORD_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    input  logic [ADDR_W-1:0] write_addr_2,
    input  logic              write_en,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              ready
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] read_data_1_q, read_data_1_d;
    logic [DATA_W-1:0] read_data_2_q, read_data_2_d;

    logic [DATA_W-1:0] bank1_q [DEPTH];
    logic [DATA_W-1:0] bank2_q [DEPTH];

    logic [IDX_W-1:0]  w_rd_idx_1;
    logic [IDX_W-1:0]  w_rd_idx_2;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_wr_bank2;
    logic              w_bank1_we;
    logic              w_bank2_we;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_unused_msbs;

    assign w_rd_idx_1    = read_addr_1[IDX_W-1:0];
    assign w_rd_idx_2    = read_addr_2[IDX_W-1:0];
    assign w_wr_idx      = write_addr_2[IDX_W-1:0];
    assign w_wr_bank2    = write_addr_2[ADDR_W-1];
    // Read ports are tied to banks by port, so read address MSBs carry no meaning.
    assign w_unused_msbs = read_addr_1[ADDR_W-1] ^ read_addr_2[ADDR_W-1];

    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        w_bank1_we    = 1'b0;
        w_bank2_we    = 1'b0;
        w_mem_idx     = clr_cnt_q;
        w_mem_data    = '0;
        read_data_1_d = '0;
        read_data_2_d = '0;
        case (state_q)
            ST_CLEAR: begin
                w_bank1_we = 1'b1;
                w_bank2_we = 1'b1;
                if (clr_cnt_q == c_LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                w_mem_idx     = w_wr_idx;
                w_mem_data    = write_data;
                w_bank1_we    = write_en & ~w_wr_bank2;
                w_bank2_we    = write_en & w_wr_bank2;
                read_data_1_d = bank1_q[w_rd_idx_1];
                read_data_2_d = bank2_q[w_rd_idx_2];
`ifdef DSPMEM_FWD_EN
                if (w_bank1_we && (w_rd_idx_1 == w_wr_idx)) begin
                    read_data_1_d = write_data;
                end
                if (w_bank2_we && (w_rd_idx_2 == w_wr_idx)) begin
                    read_data_2_d = write_data;
                end
`else
                // Read-first: the registered read returns pre-write contents.
`endif
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            clr_cnt_q     <= '0;
            read_data_1_q <= '0;
            read_data_2_q <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            read_data_1_q <= read_data_1_d;
            read_data_2_q <= read_data_2_d;
        end
    end

    // Storage is not reset directly; the clear sequence zero-fills it.
    always_ff @(posedge clk) begin
        if (!rst && w_bank1_we) begin
            bank1_q[w_mem_idx] <= w_mem_data;
        end
        if (!rst && w_bank2_we) begin
            bank2_q[w_mem_idx] <= w_mem_data;
        end
    end

    assign read_data_1 = read_data_1_q;
    assign read_data_2 = read_data_2_q;
    assign ready       = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_dsp_dual_bank_mem.sv
//------------------------------------------------------------------------------
// tb_dsp_dual_bank_mem
// Self-checking bench: directed scenarios plus randomized traffic compared
// against an array-based reference model of the dual-bank memory.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dsp_dual_bank_mem;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int IDX_W  = ADDR_W - 1;
    localparam int DEPTH  = 1 << IDX_W;
`ifdef DSPMEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] read_addr_1;
    logic [ADDR_W-1:0] read_addr_2;
    logic [ADDR_W-1:0] write_addr_2;
    logic              write_en;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] m_b1 [DEPTH];
    logic [DATA_W-1:0] m_b2 [DEPTH];
    bit                m_clear = 1'b1;
    int                m_cnt   = 0;
    logic [DATA_W-1:0] exp_rd1;
    logic [DATA_W-1:0] exp_rd2;
    logic              exp_ready;

    dsp_dual_bank_mem #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .read_addr_1 (read_addr_1),
        .read_addr_2 (read_addr_2),
        .write_addr_2(write_addr_2),
        .write_en    (write_en),
        .write_data  (write_data),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, updating the model with the behaviour that edge must have.
    task automatic tick();
        int i1, i2, iw;
        logic [DATA_W-1:0] n1, n2;
        i1 = int'(read_addr_1[IDX_W-1:0]);
        i2 = int'(read_addr_2[IDX_W-1:0]);
        iw = int'(write_addr_2[IDX_W-1:0]);
        n1 = '0;
        n2 = '0;
        if (rst) begin
            m_clear = 1'b1;
            m_cnt   = 0;
        end else if (m_clear) begin
            m_b1[m_cnt] = '0;
            m_b2[m_cnt] = '0;
            if (m_cnt == DEPTH - 1) m_clear = 1'b0;
            else m_cnt = m_cnt + 1;
        end else begin
            n1 = m_b1[i1];
            n2 = m_b2[i2];
            if (write_en) begin
                if (write_addr_2[ADDR_W-1]) begin
                    if (FWD && iw == i2) n2 = write_data;
                    m_b2[iw] = write_data;
                end else begin
                    if (FWD && iw == i1) n1 = write_data;
                    m_b1[iw] = write_data;
                end
            end
        end
        @(posedge clk);
        #1;
        exp_rd1   = n1;
        exp_rd2   = n2;
        exp_ready = !m_clear;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (read_data_1 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rd1: got %h expected 0000", read_data_1);
        end
        checks++;
        if (read_data_2 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rd2: got %h expected 0000", read_data_2);
        end
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0", ready);
        end
        rst = 1'b0;
        // A store pulse mid-clear must be dropped.
        for (int k = 1; k <= DEPTH; k++) begin
            write_en     = (k == 3);
            write_addr_2 = '0;
            write_data   = 16'hAAAA;
            tick();
            checks++;
            if (ready !== (k == DEPTH)) begin
                failures++;
                $display("FAIL clear_ready k=%0d: got %b expected %b", k, ready, (k == DEPTH));
            end
        end
        write_en = 1'b0;
    endtask

    task automatic test_clear_readback();
        for (int i = 0; i < DEPTH; i++) begin
            read_addr_1 = {1'($urandom_range(0, 1)), IDX_W'(i)};
            read_addr_2 = {1'($urandom_range(0, 1)), IDX_W'(i)};
            tick();
            checks++;
            if (read_data_1 !== 16'h0000) begin
                failures++;
                $display("FAIL clear_rd1 idx=%0d: got %h expected 0000", i, read_data_1);
            end
            checks++;
            if (read_data_2 !== 16'h0000) begin
                failures++;
                $display("FAIL clear_rd2 idx=%0d: got %h expected 0000", i, read_data_2);
            end
        end
    endtask

    task automatic test_store_load();
        write_en     = 1'b1;
        write_addr_2 = {1'b1, IDX_W'(5)};
        write_data   = 16'hBEEF;
        tick();
        write_en    = 1'b0;
        read_addr_1 = {1'b0, IDX_W'(5)};
        read_addr_2 = {1'b0, IDX_W'(5)};
        tick();
        checks++;
        if (read_data_2 !== 16'hBEEF) begin
            failures++;
            $display("FAIL store_load_rd2: got %h expected beef", read_data_2);
        end
        checks++;
        if (read_data_1 !== 16'h0000) begin
            failures++;
            $display("FAIL store_load_rd1: got %h expected 0000", read_data_1);
        end
    endtask

    task automatic test_steering();
        write_en     = 1'b1;
        write_addr_2 = {1'b0, IDX_W'(3)};
        write_data   = 16'h1234;
        tick();
        write_en    = 1'b0;
        read_addr_1 = {1'b1, IDX_W'(3)};
        read_addr_2 = {1'b1, IDX_W'(3)};
        tick();
        checks++;
        if (read_data_1 !== 16'h1234) begin
            failures++;
            $display("FAIL steering_rd1: got %h expected 1234", read_data_1);
        end
        checks++;
        if (read_data_2 !== 16'h0000) begin
            failures++;
            $display("FAIL steering_rd2: got %h expected 0000", read_data_2);
        end
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] want;
        write_en     = 1'b1;
        write_addr_2 = {1'b1, IDX_W'(7)};
        write_data   = 16'h0001;
        read_addr_2  = '0;
        tick();
        write_data  = 16'h00FF;
        read_addr_2 = {1'b0, IDX_W'(7)};
        tick();
        want = FWD ? 16'h00FF : 16'h0001;
        checks++;
        if (read_data_2 !== want) begin
            failures++;
            $display("FAIL collision_same_cycle: got %h expected %h", read_data_2, want);
        end
        write_en = 1'b0;
        tick();
        checks++;
        if (read_data_2 !== 16'h00FF) begin
            failures++;
            $display("FAIL collision_next_cycle: got %h expected 00ff", read_data_2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            write_en     = 1'($urandom_range(0, 1));
            write_addr_2 = {1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 7))};
            write_data   = DATA_W'($urandom);
            read_addr_1  = {1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 7))};
            read_addr_2  = {1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 7))};
            tick();
            checks++;
            if (read_data_1 !== exp_rd1) begin
                failures++;
                $display("FAIL random_rd1 n=%0d: got %h expected %h", n, read_data_1, exp_rd1);
            end
            checks++;
            if (read_data_2 !== exp_rd2) begin
                failures++;
                $display("FAIL random_rd2 n=%0d: got %h expected %h", n, read_data_2, exp_rd2);
            end
            checks++;
            if (ready !== exp_ready) begin
                failures++;
                $display("FAIL random_ready n=%0d: got %b expected %b", n, ready, exp_ready);
            end
        end
        write_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 16; i++) begin
            write_en     = 1'b1;
            write_addr_2 = {1'(i & 1), IDX_W'(i >> 1)};
            write_data   = DATA_W'(16'h0100 + i);
            tick();
        end
        write_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < DEPTH / 2; k++) tick();
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL midclear_ready: got %b expected 0", ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            checks++;
            if (ready !== (k == DEPTH)) begin
                failures++;
                $display("FAIL restart_ready k=%0d: got %b expected %b", k, ready, (k == DEPTH));
            end
        end
        for (int i = 0; i < 8; i++) begin
            read_addr_1 = {1'b0, IDX_W'(i)};
            read_addr_2 = {1'b1, IDX_W'(i)};
            tick();
            checks++;
            if (read_data_1 !== 16'h0000 || read_data_2 !== 16'h0000) begin
                failures++;
                $display("FAIL restart_clear idx=%0d: got %h/%h expected 0000/0000",
                         i, read_data_1, read_data_2);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        read_addr_1  = '0;
        read_addr_2  = '0;
        write_addr_2 = '0;
        write_en     = 1'b0;
        write_data   = '0;
        test_reset();
        test_clear_readback();
        test_store_load();
        test_steering();
        test_collision();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
